// File: rtl/branch_resolve.sv
// EX-stage branch resolution: registers the taken decision, issues a one-cycle PC
// redirect and sequences IF/ID flush cycles. Optional counters: BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int DELAY_SLOT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [2:0]        br_flag,
  input  logic              cmp_s,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              flush_id,
  output logic              busy,
  output logic              bad_flag,
`ifdef BRANCH_RESOLVE_STATS_EN
  input  logic              stat_clear,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_not_taken,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: br_valid is a level held upstream; a branch is consumed on a rising
  // edge only when stall=0 and the FSM is IDLE, otherwise it is left for a later edge.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic FLUSH_ID_ON = (DELAY_SLOT == 0);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic                flush_if_q, flush_if_d;
  logic                flush_id_q, flush_id_d;
  logic                busy_q, busy_d;
  logic                bad_flag_q, bad_flag_d;

  logic accept;
  logic flag_ok;
  logic taken;

  always_comb begin
    flag_ok = !((br_flag == 3'b011) || (br_flag == 3'b101));
    accept  = br_valid && !stall && (state_q == IDLE);
    taken   = accept && cmp_s && flag_ok;
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_if_d       = flush_if_q;
    flush_id_d       = flush_id_q;
    busy_d           = busy_q;
    bad_flag_d       = bad_flag_q;
    if (!stall) begin
      bad_flag_d = accept && !flag_ok;
      case (state_q)
        IDLE: begin
          if (taken) begin
            state_d          = REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = br_target;
            flush_if_d       = 1'b1;
            flush_id_d       = FLUSH_ID_ON;
            busy_d           = 1'b1;
          end
        end
        REDIRECT: begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES <= 1) begin
            state_d    = IDLE;
            flush_if_d = 1'b0;
            flush_id_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            state_d = FLUSH;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          // Leaving on the edge where the counter reaches zero gives FLUSH_CYCLES total.
          if (cnt_q <= 3'd1) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            flush_if_d = 1'b0;
            flush_id_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d          = IDLE;
          cnt_d            = 3'd0;
          redirect_valid_d = 1'b0;
          flush_if_d       = 1'b0;
          flush_id_d       = 1'b0;
          busy_d           = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_q       <= 1'b0;
      flush_id_q       <= 1'b0;
      busy_q           <= 1'b0;
      bad_flag_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_if_q       <= flush_if_d;
      flush_id_q       <= flush_id_d;
      busy_q           <= busy_d;
      bad_flag_q       <= bad_flag_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = flush_if_q;
  assign flush_id       = flush_id_q;
  assign busy           = busy_q;
  assign bad_flag       = bad_flag_q;
  assign dbg_state      = state_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_not_taken_q, stat_not_taken_d;

  // Clear takes priority over a same-cycle increment; counters wrap naturally.
  always_comb begin
    stat_taken_d     = stat_taken_q;
    stat_not_taken_d = stat_not_taken_q;
    if (stat_clear) begin
      stat_taken_d     = 32'd0;
      stat_not_taken_d = 32'd0;
    end else if (accept) begin
      if (taken) stat_taken_d = stat_taken_q + 32'd1;
      else       stat_not_taken_d = stat_not_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken_q     <= 32'd0;
      stat_not_taken_q <= 32'd0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: two instances (FLUSH_CYCLES=1/DELAY_SLOT=1 and
// FLUSH_CYCLES=3/DELAY_SLOT=0) fed the same stimulus table, plus hand sequences.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_flag;
  logic        cmp_s;
  logic [31:0] br_target;
  logic        stall;

  logic        rv_a, fif_a, fid_a, busy_a, bad_a;
  logic [31:0] pc_a;
  logic [1:0]  st_a;
  logic        rv_b, fif_b, fid_b, busy_b, bad_b;
  logic [31:0] pc_b;
  logic [1:0]  st_b;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic        stat_clear;
  logic [31:0] tk_a, nt_a, tk_b, nt_b;
`endif

  int total;
  int bad;

  branch_resolve dut_a (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_flag(br_flag), .cmp_s(cmp_s),
    .br_target(br_target), .stall(stall), .redirect_valid(rv_a), .redirect_pc(pc_a),
    .flush_if(fif_a), .flush_id(fid_a), .busy(busy_a), .bad_flag(bad_a),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_clear(stat_clear), .stat_taken(tk_a), .stat_not_taken(nt_a),
`endif
    .dbg_state(st_a)
  );

  branch_resolve #(.ADDR_W(32), .FLUSH_CYCLES(3), .DELAY_SLOT(0)) dut_b (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_flag(br_flag), .cmp_s(cmp_s),
    .br_target(br_target), .stall(stall), .redirect_valid(rv_b), .redirect_pc(pc_b),
    .flush_if(fif_b), .flush_id(fid_b), .busy(busy_b), .bad_flag(bad_b),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_clear(stat_clear), .stat_taken(tk_b), .stat_not_taken(nt_b),
`endif
    .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // expected flags are {redirect_valid, flush_if, flush_id, busy, bad_flag}
  typedef struct {
    logic        bv;
    logic [2:0]  flag;
    logic        s;
    logic [31:0] tgt;
    logic        st;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];
  logic [41:0] exp_q[$];

  task automatic add(input logic bv, input logic [2:0] flag, input logic s, input logic [31:0] tgt,
                     input logic st, input logic [4:0] ea, input logic [4:0] eb, input logic [31:0] epc);
    vec_t v;
    v.bv = bv; v.flag = flag; v.s = s; v.tgt = tgt; v.st = st; v.ea = ea; v.eb = eb; v.epc = epc;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver: apply inputs at the falling edge, DUT samples at the next rising edge
  task automatic drive(input logic bv, input logic [2:0] flag, input logic s,
                       input logic [31:0] tgt, input logic st);
    br_valid = bv; br_flag = flag; cmp_s = s; br_target = tgt; stall = st;
  endtask

  task automatic cycle(input logic bv, input logic [2:0] flag, input logic s,
                       input logic [31:0] tgt, input logic st);
    drive(bv, flag, s, tgt, st);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a outs"}, 64'({rv_a, fif_a, fid_a, busy_a, bad_a}), 64'd0);
    check({tag, " b outs"}, 64'({rv_b, fif_b, fid_b, busy_b, bad_b}), 64'd0);
    check({tag, " a state"}, 64'(st_a), 64'd0);
    check({tag, " b state"}, 64'(st_b), 64'd0);
  endtask

  initial begin
    logic [41:0] e;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
`ifdef BRANCH_RESOLVE_STATS_EN
    stat_clear = 1'b0;
`endif

    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0);
    add(1, 3'b001, 1, 32'h0040_0100, 0, 5'b11010, 5'b11110, 32'h0040_0100);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h0040_0100);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h0040_0100);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0040_0100);
    add(1, 3'b000, 0, 32'h0000_0bad, 0, 5'b00000, 5'b00000, 32'h0040_0100);
    add(1, 3'b011, 1, 32'h0000_0bad, 0, 5'b00001, 5'b00001, 32'h0040_0100);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0040_0100);
    add(1, 3'b101, 0, 32'h0000_0bad, 0, 5'b00001, 5'b00001, 32'h0040_0100);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0040_0100);
    add(1, 3'b010, 1, 32'h1234_5678, 0, 5'b11010, 5'b11110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         1, 5'b11010, 5'b11110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         1, 5'b11010, 5'b11110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         1, 5'b00000, 5'b01110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h1234_5678);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h1234_5678);
    add(1, 3'b111, 1, 32'hdead_bee0, 1, 5'b00000, 5'b00000, 32'h1234_5678);
    add(1, 3'b111, 1, 32'hdead_bee0, 0, 5'b11010, 5'b11110, 32'hdead_bee0);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'hdead_bee0);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'hdead_bee0);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'hdead_bee0);
    add(1, 3'b100, 0, 32'h0000_0bad, 0, 5'b00000, 5'b00000, 32'hdead_bee0);
    add(1, 3'b110, 1, 32'h0000_0004, 0, 5'b11010, 5'b11110, 32'h0000_0004);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h0000_0004);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b01110, 32'h0000_0004);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0000_0004);
    add(1, 3'b011, 1, 32'h0000_0bad, 1, 5'b00000, 5'b00000, 32'h0000_0004);
    add(1, 3'b011, 1, 32'h0000_0bad, 0, 5'b00001, 5'b00001, 32'h0000_0004);
    add(0, 3'b000, 0, 32'h0,         0, 5'b00000, 5'b00000, 32'h0000_0004);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset a pc", 64'(pc_a), 64'd0);
    check("reset b pc", 64'(pc_b), 64'd0);
    reset = 1'b0;

    // table-driven run; a branch is never offered while either instance is busy
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].bv) check($sformatf("row%0d issue while busy", i), 64'(busy_a | busy_b), 64'd0);
      drive(tbl[i].bv, tbl[i].flag, tbl[i].s, tbl[i].tgt, tbl[i].st);
      exp_q.push_back({tbl[i].ea, tbl[i].eb, tbl[i].epc});
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("row%0d a flags", i), 64'({rv_a, fif_a, fid_a, busy_a, bad_a}), 64'(e[41:37]));
      check($sformatf("row%0d b flags", i), 64'({rv_b, fif_b, fid_b, busy_b, bad_b}), 64'(e[36:32]));
      check($sformatf("row%0d a pc", i), 64'(pc_a), 64'(e[31:0]));
      check($sformatf("row%0d b pc", i), 64'(pc_b), 64'(e[31:0]));
    end

    // async reset in the middle of dut_b's flush
    cycle(1'b1, 3'b010, 1'b1, 32'h0000_8000, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    check("pre-reset b flush", 64'({fif_b, fid_b, busy_b}), 64'h7);
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    check("async reset b pc", 64'(pc_b), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    check_all_zero("post reset idle");
    cycle(1'b1, 3'b001, 1'b1, 32'h0000_00c0, 1'b0);
    check("post reset a redirect", 64'({rv_a, fif_a, busy_a}), 64'h7);
    check("post reset b redirect", 64'({rv_b, fif_b, fid_b, busy_b}), 64'hf);
    check("post reset pc", 64'(pc_a), 64'h0000_00c0);
    cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    check("post reset a drop", 64'({rv_a, fif_a, busy_a}), 64'h0);
    check("post reset b second", 64'({rv_b, fif_b, busy_b}), 64'h3);
    repeat (2) cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    check("post reset b idle", 64'(busy_b), 64'd0);

`ifdef BRANCH_RESOLVE_STATS_EN
    stat_clear = 1'b1;
    cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    stat_clear = 1'b0;
    check("stats cleared taken", 64'(tk_a), 64'd0);
    check("stats cleared not", 64'(nt_b), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 3'($urandom_range(0, 1)), 1'b1, 32'($urandom_range(0, 4095)) << 2, 1'b0);
      repeat (3) cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    end
    cycle(1'b1, 3'b000, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 3'b101, 1'b1, 32'h0, 1'b0);
    cycle(1'b1, 3'b111, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    check("stats a taken", 64'(tk_a), 64'd5);
    check("stats a not", 64'(nt_a), 64'd3);
    check("stats b taken", 64'(tk_b), 64'd5);
    check("stats b not", 64'(nt_b), 64'd3);
    stat_clear = 1'b1;
    cycle(1'b1, 3'b001, 1'b1, 32'h0000_0100, 1'b0);
    stat_clear = 1'b0;
    check("clear vs accept taken", 64'(tk_a), 64'd0);
    check("clear vs accept not", 64'(nt_a), 64'd0);
    repeat (3) cycle(1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the compare unit's taken bit S.
- Registers the branch decision, drives a one-cycle PC redirect to IF, and sequences pipeline flush cycles through a small FSM.
- Sits between the ALU compare output and the PC-select / hazard logic.
- Flags illegal compare codes instead of letting them resolve as taken.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- FLUSH_CYCLES, 1, cycles flush_if is held after a taken branch (1..7).
- DELAY_SLOT, 1, 1 = delay-slot instruction in ID survives; 0 = ID also flushed.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- br_valid  input  1  branch instruction in EX this cycle.
- br_flag  input  3  compare code sent to the compare unit (001 EQ, 000 NEQ, 010 LT, 110 LEZ, 100 GEZ, 111 GTZ).
- cmp_s  input  1  taken bit from the compare unit.
- br_target  input  ADDR_W  computed branch target.
- stall  input  1  pipeline stall; freezes this block.
- redirect_valid  output  1  one-cycle PC-load strobe.
- redirect_pc  output  ADDR_W  PC to load when redirect_valid is high.
- flush_if  output  1  kill the instruction in IF.
- flush_id  output  1  kill the instruction in ID (only when DELAY_SLOT=0).
- busy  output  1  FSM not IDLE; hazard unit blocks issue of a new branch.
- bad_flag  output  1  one-cycle pulse: br_valid with an undefined br_flag (011, 101).

Behaviour:
- Reset (async, immediate): state=IDLE; redirect_valid=0, redirect_pc=0, flush_if=0, flush_id=0, busy=0, bad_flag=0, flush counter=0.
- All outputs are registered.
- Accept: a branch is accepted on a rising edge when br_valid=1, stall=0 and state=IDLE.
- Taken condition: cmp_s=1 AND br_flag is defined. An undefined br_flag resolves not-taken regardless of cmp_s and pulses bad_flag the next cycle.
- IDLE:
  - Accepted and taken -> REDIRECT. Latch br_target into redirect_pc; next cycle redirect_valid=1, flush_if=1, flush_id=~DELAY_SLOT, busy=1.
  - Accepted and not taken -> stay IDLE; no outputs change except bad_flag.
- REDIRECT (exactly one unstalled cycle):
  - redirect_valid drops after that cycle.
  - If FLUSH_CYCLES=1 -> IDLE, all flush outputs cleared.
  - Else -> FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH:
  - flush_if=1, flush_id=~DELAY_SLOT, redirect_valid=0.
  - Counter decrements each unstalled cycle; when it reaches 0, go to IDLE and clear flush outputs and busy on the same edge.
- Latency: taken branch to redirect_valid is 1 cycle. Total flush duration is FLUSH_CYCLES unstalled cycles.
- stall=1: state, counter and all outputs hold their values. A redirect_valid held high across a stall is one logical redirect; PC logic loads on the first unstalled cycle.
- br_valid while busy: ignored, no state change. This is a hazard-unit contract violation; the bench checks it never occurs.
- br_valid and stall together in IDLE: not accepted. The upstream register holds br_valid, so the branch is taken on the first unstalled cycle.
- Reset mid-REDIRECT/FLUSH: outputs drop immediately, with no residual redirect after reset release.
- redirect_pc holds its last latched value when not redirecting (no re-zeroing).

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined:
  - Adds outputs stat_taken[31:0] and stat_not_taken[31:0], plus input stat_clear.
  - Counters increment on each accepted branch per its resolution. An undefined flag counts as not-taken.
  - Counters wrap at 2^32-1 -> 0.
  - Both reset and stat_clear zero them. stat_clear wins over a simultaneous increment.
- When undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Taken EQ: reset, then br_valid=1, br_flag=001, cmp_s=1, br_target=0x0040_0100 -> next cycle redirect_valid=1, redirect_pc=0x0040_0100, flush_if=1, flush_id=0 (DELAY_SLOT=1), busy=1; all low one cycle later.
- Not taken plus illegal flag: br_flag=000, cmp_s=0 -> no redirect. Then br_flag=011, cmp_s=1 -> no redirect, bad_flag pulses exactly 1 cycle.
- Multi-cycle flush: FLUSH_CYCLES=3, DELAY_SLOT=0, taken LT -> flush_if and flush_id high exactly 3 cycles, redirect_valid high only in the first, busy high 3 cycles.
- Stall interaction: stall=1 asserted in the redirect cycle for 2 cycles -> redirect_valid stays high 3 cycles total, flush sequence resumes afterwards; br_valid with stall=1 in IDLE is accepted only after stall drops.
- Async reset mid-FLUSH: assert reset between clock edges -> all outputs 0 before the next edge; after release, state is IDLE and a new taken branch redirects normally.
- Stats (BRANCH_RESOLVE_STATS_EN): 5 taken plus 3 not-taken branches -> stat_taken=5, stat_not_taken=3. stat_clear in the same cycle as an accept -> both counters 0.
